pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_stage.sv | 88 ++++++++
 rtl/pipe_shifter.sv | 73 +++++++
 tb/tb_pipe_shifter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encoding, fill kinds and
// the shift-amount width helper.
package shift_pkg;

  localparam int unsigned OpW = 3;

  typedef enum logic [OpW-1:0] {
    OpSll = 3'b000,
    OpSrl = 3'b001,
    OpSra = 3'b010,
    OpRol = 3'b011,
    OpRor = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    FillZero,
    FillSign,
    FillRot
  } fill_e;

  function automatic int unsigned shamt_w(input int unsigned xlen);
    return $clog2(xlen);
  endfunction

  function automatic fill_e op_fill(input logic [OpW-1:0] op);
    case (op)
      OpSra:        return FillSign;
      OpRol, OpRor: return FillRot;
      default:      return FillZero;
    endcase
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: applies amount bits Hi..Lo as binary-weighted sub-shifts, then
// registers the result together with the op, amount and captured sign.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ShamtW = 5,
  parameter int          Hi     = 4,
  parameter int          Lo     = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [ShamtW-1:0] amt_i,
  input  logic [OpW-1:0]    op_i,
  input  logic              sign_i,
  output logic              valid_o,
  output logic [XLEN-1:0]   data_o,
  output logic [ShamtW-1:0] amt_o,
  output logic [OpW-1:0]    op_o,
  output logic              sign_o
);

  logic              valid_q;
  logic [XLEN-1:0]   data_q, data_d;
  logic [ShamtW-1:0] amt_q;
  logic [OpW-1:0]    op_q;
  logic              sign_q;

  logic [XLEN-1:0] shifted, spill, fill_word;
  logic            left, pass;
  fill_e           fill;
  int unsigned     sh;

  always_comb begin
    data_d    = data_i;
    shifted   = '0;
    spill     = '0;
    sh        = 0;
    fill      = op_fill(op_i);
    left      = (op_i == OpSll) || (op_i == OpRol);
    pass      = (op_i > OpRor);
    fill_word = {XLEN{sign_i}};
    // Largest weight first; bits outside Hi..Lo belong to other stages.
    for (int k = int'(ShamtW) - 1; k >= 0; k--) begin
      if (!pass && k <= Hi && k >= Lo && amt_i[k]) begin
        sh = 32'd1 << k;
        if (left) begin
          shifted = data_d << sh;
          spill   = data_d >> (XLEN - sh);
        end else begin
          shifted = data_d >> sh;
          spill   = data_d << (XLEN - sh);
        end
        case (fill)
          FillRot:  data_d = shifted | spill;
          FillSign: data_d = shifted | (fill_word << (XLEN - sh));
          default:  data_d = shifted;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      amt_q   <= amt_i;
      op_q    <= op_i;
      sign_q  <= sign_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign op_o    = op_q;
  assign sign_o  = sign_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: STAGES registered stages with a single global advance, so
// a stalled output freezes the whole pipe.
module pipe_shifter
  import shift_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] y
);

  localparam int unsigned SHAMT_W = shamt_w(XLEN);
  localparam int          Per     = (int'(SHAMT_W) + int'(STAGES) - 1) / int'(STAGES);

  logic [STAGES:0]              vld;
  logic [STAGES:0][XLEN-1:0]    dat;
  logic [STAGES:0][SHAMT_W-1:0] amt;
  logic [STAGES:0][OpW-1:0]     opc;
  logic [STAGES:0]              sgn;
  logic                         advance;

  assign out_valid = vld[STAGES];
  assign in_ready  = out_ready | ~out_valid;
  assign advance   = in_ready;
  assign y         = dat[STAGES];

  assign vld[0] = in_valid;
  assign dat[0] = a;
  assign amt[0] = b[SHAMT_W-1:0];
  assign opc[0] = op;
  assign sgn[0] = a[XLEN-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int Hi    = int'(SHAMT_W) - 1 - s * Per;
    localparam int LoRaw = int'(SHAMT_W) - (s + 1) * Per;
    localparam int Lo    = (LoRaw < 0) ? 0 : LoRaw;

    shift_stage #(
      .XLEN   (XLEN),
      .ShamtW (SHAMT_W),
      .Hi     (Hi),
      .Lo     (Lo)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .en_i    (advance),
      .valid_i (vld[s]),
      .data_i  (dat[s]),
      .amt_i   (amt[s]),
      .op_i    (opc[s]),
      .sign_i  (sgn[s]),
      .valid_o (vld[s+1]),
      .data_o  (dat[s+1]),
      .amt_o   (amt[s+1]),
      .op_o    (opc[s+1]),
      .sign_o  (sgn[s+1])
    );
  end

  // Upper amount bits are ignored; last-stage side-band has no consumer.
  logic unused_bits;
  assign unused_bits = ^{b[XLEN-1:SHAMT_W], amt[STAGES], opc[STAGES], sgn[STAGES]};

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (32/2 main instance, 64/3 directed instance).
module tb_pipe_shifter;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0] a, b, y;
  logic [2:0]      op;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] a64, b64, y64;
  logic [2:0]  op64;

  always #5 clk = ~clk;

  pipe_shifter #(.XLEN(XLEN), .STAGES(STAGES)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  pipe_shifter #(.XLEN(64), .STAGES(3)) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid64),
    .in_ready  (in_ready64),
    .a         (a64),
    .b         (b64),
    .op        (op64),
    .out_valid (out_valid64),
    .out_ready (out_ready64),
    .y         (y64)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference semantics straight from the op definitions, on a w-bit word.
  function automatic logic [63:0] ref_shift(input logic [2:0] o, input logic [63:0] av,
                                            input logic [63:0] bv, input int w);
    logic [63:0] mask, x;
    int n;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = av & mask;
    n    = int'(bv % 64'(w));
    case (o)
      3'd0:    return (x << n) & mask;
      3'd1:    return x >> n;
      3'd2:    return (x >> n) | (x[w-1] ? (mask & ~(mask >> n)) : 64'd0);
      3'd3:    return (n == 0) ? x : (((x << n) | (x >> (w - n))) & mask);
      3'd4:    return (n == 0) ? x : (((x >> n) | (x << (w - n))) & mask);
      default: return x;
    endcase
  endfunction

  // Scoreboard push on every accepted request.
  logic [63:0] sb_tmp;
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb_tmp = ref_shift(op, 64'(a), 64'(b), XLEN);
      exp_q.push_back(sb_tmp[XLEN-1:0]);
    end
  end

  // Monitor: pop on every consumed result, and check hold behaviour while stalled.
  logic            stall_prev = 1'b0;
  logic [XLEN-1:0] y_prev;
  logic [XLEN-1:0] exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_y", 64'(y), 64'(y_prev));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got y=%h, expected no output", y);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", 64'(y), 64'(exp_v));
          n_out++;
        end
      end
      stall_prev = out_valid && !out_ready;
      y_prev     = y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request into an empty pipe; checks latency and value.
  task automatic lat32(input string name, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] req);
    int k;
    op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 10);
    check({name, "_latency"}, 64'(k), 64'(STAGES));
    check({name, "_y"}, 64'(y), 64'(req));
    tick();
  endtask

  task automatic lat64(input string name, input logic [2:0] o, input logic [63:0] av,
                       input logic [63:0] bv, input logic [63:0] req);
    int k;
    op64 = o; a64 = av; b64 = bv; in_valid64 = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready64), 64'd1);
    tick();
    in_valid64 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid64 && k < 10);
    check({name, "_latency"}, 64'(k), 64'd3);
    check({name, "_y"}, y64, req);
    check({name, "_model"}, y64, ref_shift(o, av, bv, 64));
    tick();
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int first, last, cnt, idx, acc_stall, idle_seen;
    logic saw_block, acc;
    logic [31:0] ra[4], rb[4];
    logic [2:0]  ro[4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    in_valid64 = 1'b0; out_ready64 = 1'b1; a64 = '0; b64 = '0; op64 = '0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_y", 64'(y), 64'd0);
    check("reset_out_valid64", 64'(out_valid64), 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    lat32("sra_31", 3'b010, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    lat32("ror_4", 3'b100, 32'h1234_5678, 32'h24, 32'h8123_4567);
    lat32("rol_4", 3'b011, 32'h1234_5678, 32'h24, 32'h2345_6781);
    lat32("sll_0", 3'b000, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
    lat32("pass_7", 3'b111, 32'hCAFE_F00D, 32'd5, 32'hCAFE_F00D);

    lat64("srl48_64", 3'b001, 64'hFFFF_0000_0000_0000, 64'd48, 64'h0000_0000_0000_FFFF);
    lat64("pass_64", 3'b111, 64'h0123_4567_89AB_CDEF, 64'd9, 64'h0123_4567_89AB_CDEF);
    lat64("sra_64", 3'b010, 64'h8000_0000_0000_0001, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);

    // Back-to-back SLL of 1 by 0..31.
    first = -1; last = -1; cnt = 0;
    op = 3'b000; a = 32'd1; b = 32'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      tick();
      if (i < 31) b = 32'(i + 1);
      else in_valid = 1'b0;
    end
    check("b2b_count", 64'(cnt), 64'd32);
    check("b2b_no_gaps", 64'(last - first), 64'd31);
    check("b2b_first_latency", 64'(first), 64'(STAGES));

    // Output stall with four requests offered.
    for (int i = 0; i < 4; i++) begin
      ro[i] = 3'($urandom_range(0, 4)); ra[i] = $urandom; rb[i] = $urandom;
    end
    idx = 0; acc_stall = 0; saw_block = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; op = ro[0]; a = ra[0]; b = rb[0];
    for (int c = 0; c < 40 && idx < 4; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c < 5 && !in_ready) saw_block = 1'b1;
      if (c < 5 && acc) acc_stall++;
      tick();
      if (acc) idx++;
      if (c == 4) out_ready = 1'b1;
      if (idx < 4) begin
        op = ro[idx]; a = ra[idx]; b = rb[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stall_in_ready_drops", 64'(saw_block), 64'd1);
    check("stall_accepted", 64'(acc_stall), 64'(STAGES));
    check("stall_all_offered", 64'(idx), 64'd4);
    drain();

    // Reset with two results in flight.
    out_ready = 1'b1; op = 3'b001; a = $urandom; b = 32'd3; in_valid = 1'b1;
    @(negedge clk);
    tick();
    a = $urandom;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 64'(out_valid), 64'd0);
    check("mid_reset_in_ready", 64'(in_ready), 64'd1);
    check("mid_reset_y", 64'(y), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    lat32("post_reset_accept", 3'b000, 32'h0000_00F0, 32'd4, 32'h0000_0F00);
    idle_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) idle_seen++;
    end
    tick();
    check("post_reset_no_stale", 64'(idle_seen), 64'd0);

    // Randomized traffic with random back-pressure.
    in_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
